// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - programmable up/down counter with prescaler and wrap/saturate/one-shot end modes
module param_updown_counter #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           PRESCALE_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clear_ovf,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  overflow,
    output logic                  running
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);
    localparam logic [1:0]            MODE_SAT     = 2'b01;
    localparam logic [1:0]            MODE_ONESHOT = 2'b10;

    state_t                state;
    logic [PRESCALE_W-1:0] ps_cnt;
    logic                  tick;
    logic                  terminal;
    logic [WIDTH-1:0]      step_value;
    logic [WIDTH-1:0]      end_value;

    assign tick     = enable && (ps_cnt == prescale);
    assign terminal = dir ? (count == '0) : (count >= limit);

    always_comb begin
        step_value = dir ? (count - CNT_ONE) : (count + CNT_ONE);
        // Mode 11 falls through to wrap behaviour.
        if (mode == MODE_SAT) begin
            end_value = dir ? '0 : limit;
        end else if (mode == MODE_ONESHOT) begin
            end_value = count;
        end else begin
            end_value = dir ? limit : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= RESET_VALUE;
            tc       <= 1'b0;
            overflow <= 1'b0;
            running  <= 1'b1;
            state    <= RUN;
            ps_cnt   <= '0;
        end else begin
            tc <= 1'b0;
            if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (load) begin
                count   <= load_value;
                state   <= RUN;
                running <= 1'b1;
                ps_cnt  <= '0;
            end else begin
                if (enable) begin
                    ps_cnt <= tick ? '0 : (ps_cnt + PS_ONE);
                end
                if (state == DONE) begin
                    // Ticks are swallowed here; leaving one-shot mode releases the counter.
                    if (mode != MODE_ONESHOT) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end else if (tick) begin
                    if (terminal) begin
                        count    <= end_value;
                        tc       <= 1'b1;
                        overflow <= 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            state   <= DONE;
                            running <= 1'b0;
                        end
                    end else begin
                        count <= step_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - vector table and scoreboard bench for param_updown_counter
module tb_param_updown_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;
    localparam logic [W-1:0] RV = 8'hC5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic          dir = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  limit = '0;
    logic [PW-1:0] prescale = '0;
    logic          clear_ovf = 1'b0;
    logic [W-1:0]  count;
    logic          tc;
    logic          overflow;
    logic          running;

    int checks = 0;
    int errors = 0;

    param_updown_counter #(
        .WIDTH(W),
        .RESET_VALUE(RV),
        .PRESCALE_W(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .load(load),
        .load_value(load_value),
        .dir(dir),
        .mode(mode),
        .limit(limit),
        .prescale(prescale),
        .clear_ovf(clear_ovf),
        .count(count),
        .tc(tc),
        .overflow(overflow),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          en;
        logic          ld;
        logic [W-1:0]  lv;
        logic          dr;
        logic [1:0]    md;
        logic [W-1:0]  lim;
        logic [PW-1:0] ps;
        logic          co;
        logic [W-1:0]  c;
        logic          t;
        logic          o;
        logic          r;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] c;
        logic         t;
        logic         o;
        logic         r;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input string name, input logic en, input logic ld, input logic [W-1:0] lv,
                                input logic dr, input logic [1:0] md, input logic [W-1:0] lim,
                                input logic [PW-1:0] ps, input logic co, input logic [W-1:0] c,
                                input logic t, input logic o, input logic r);
        vec_t v;
        v.name = name; v.en = en; v.ld = ld; v.lv = lv; v.dr = dr; v.md = md; v.lim = lim;
        v.ps = ps; v.co = co; v.c = c; v.t = t; v.o = o; v.r = r;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        enable = v.en; load = v.ld; load_value = v.lv; dir = v.dr; mode = v.md;
        limit = v.lim; prescale = v.ps; clear_ovf = v.co;
        e.name = v.name; e.c = v.c; e.t = v.t; e.o = v.o; e.r = v.r;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            check({e.name, ".count"}, 32'(count), 32'(e.c));
            check({e.name, ".tc"}, 32'(tc), 32'(e.t));
            check({e.name, ".overflow"}, 32'(overflow), 32'(e.o));
            check({e.name, ".running"}, 32'(running), 32'(e.r));
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            sample();
        end
        vecs.delete();
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("reset.count", 32'(count), 32'(RV));
        check("reset.tc", 32'(tc), 32'(0));
        check("reset.overflow", 32'(overflow), 32'(0));
        check("reset.running", 32'(running), 32'(1));
        @(negedge clk);
        reset = 1'b0;

        //   name          en ld lv     dr md     lim    ps co  count  t  o  r
        add("free_up0",    1, 0, 8'h0,  0, 2'b00, 8'hFF, 0, 0, 8'hC6, 0, 0, 1);
        add("free_up1",    1, 0, 8'h0,  0, 2'b00, 8'hFF, 0, 0, 8'hC7, 0, 0, 1);
        add("free_up2",    1, 0, 8'h0,  0, 2'b00, 8'hFF, 0, 0, 8'hC8, 0, 0, 1);
        add("wrap_load",   1, 1, 8'd8,  0, 2'b00, 8'd9,  0, 0, 8'd8,  0, 0, 1);
        add("wrap_up",     1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd9,  0, 0, 1);
        add("wrap_tc",     1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd0,  1, 1, 1);
        add("wrap_after",  1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd1,  0, 1, 1);
        add("clr_ovf",     1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 1, 8'd2,  0, 0, 1);
        add("sat_load",    1, 1, 8'd2,  1, 2'b01, 8'd9,  2, 0, 8'd2,  0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            add($sformatf("sat_dn%0d", k), 1, 0, 8'd0, 1, 2'b01, 8'd9, 2, 0,
                (k < 3) ? 8'd2 : ((k < 6) ? 8'd1 : 8'd0),
                (k >= 9) && (k % 3 == 0), k >= 9, 1);
        end
        add("os_load",     1, 1, 8'd0,  0, 2'b10, 8'd3,  0, 1, 8'd0,  0, 0, 1);
        add("os_1",        1, 0, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd1,  0, 0, 1);
        add("os_2",        1, 0, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd2,  0, 0, 1);
        add("os_3",        1, 0, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd3,  0, 0, 1);
        add("os_tc",       1, 0, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd3,  1, 1, 0);
        for (int k = 0; k < 10; k++) begin
            add($sformatf("os_done%0d", k), 1, 0, 8'd0, 0, 2'b10, 8'd3, 0, 0, 8'd3, 0, 1, 0);
        end
        add("os_reload",   1, 1, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd0,  0, 1, 1);
        add("os_resume",   1, 0, 8'd0,  0, 2'b10, 8'd3,  0, 0, 8'd1,  0, 1, 1);
        add("sim_load",    1, 1, 8'd7,  0, 2'b00, 8'd9,  0, 1, 8'd7,  0, 0, 1);
        add("sim_8",       1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd8,  0, 0, 1);
        add("sim_9",       1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd9,  0, 0, 1);
        add("sim_set_clr", 1, 0, 8'd0,  0, 2'b00, 8'd9,  0, 1, 8'd0,  1, 1, 1);
        add("m11_load",    1, 1, 8'd9,  0, 2'b11, 8'd9,  0, 0, 8'd9,  0, 1, 1);
        add("m11_wrap",    1, 0, 8'd0,  0, 2'b11, 8'd9,  0, 0, 8'd0,  1, 1, 1);
        add("hold0",       0, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd0,  0, 1, 1);
        add("hold1",       0, 0, 8'd0,  0, 2'b00, 8'd9,  0, 0, 8'd0,  0, 1, 1);
        add("lim0_load",   1, 1, 8'd5,  0, 2'b00, 8'd0,  0, 1, 8'd5,  0, 0, 1);
        add("lim0_up_a",   1, 0, 8'd0,  0, 2'b00, 8'd0,  0, 0, 8'd0,  1, 1, 1);
        add("lim0_up_b",   1, 0, 8'd0,  0, 2'b00, 8'd0,  0, 0, 8'd0,  1, 1, 1);
        add("lim0_dn",     1, 0, 8'd0,  1, 2'b00, 8'd0,  0, 0, 8'd0,  1, 1, 1);
        add("lim0_sat",    1, 0, 8'd0,  0, 2'b01, 8'd0,  0, 0, 8'd0,  1, 1, 1);
        add("above_load",  1, 1, 8'd20, 1, 2'b00, 8'd9,  0, 1, 8'd20, 0, 0, 1);
        add("above_dn1",   1, 0, 8'd0,  1, 2'b00, 8'd9,  0, 0, 8'd19, 0, 0, 1);
        add("above_dn2",   1, 0, 8'd0,  1, 2'b00, 8'd9,  0, 0, 8'd18, 0, 0, 1);
        add("satup_load",  1, 1, 8'd8,  0, 2'b01, 8'd9,  0, 1, 8'd8,  0, 0, 1);
        add("satup_9",     1, 0, 8'd0,  0, 2'b01, 8'd9,  0, 0, 8'd9,  0, 0, 1);
        add("satup_tc1",   1, 0, 8'd0,  0, 2'b01, 8'd9,  0, 0, 8'd9,  1, 1, 1);
        add("satup_tc2",   1, 0, 8'd0,  0, 2'b01, 8'd9,  0, 0, 8'd9,  1, 1, 1);
        add("mid_load",    1, 1, 8'd3,  0, 2'b00, 8'hFF, 2, 0, 8'd3,  0, 1, 1);
        for (int k = 1; k <= 7; k++) begin
            add($sformatf("mid_run%0d", k), 1, 0, 8'd0, 0, 2'b00, 8'hFF, 2, 0,
                (k < 3) ? 8'd3 : ((k < 6) ? 8'd4 : 8'd5), 0, 1, 1);
        end
        run_table();

        // Reset lands between edges with the prescaler part-way through a period.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset.count", 32'(count), 32'(RV));
        check("areset.tc", 32'(tc), 32'(0));
        check("areset.overflow", 32'(overflow), 32'(0));
        check("areset.running", 32'(running), 32'(1));
        #1 reset = 1'b0;
        add("post_rst1",   1, 0, 8'd0,  0, 2'b00, 8'hFF, 2, 0, RV,        0, 0, 1);
        add("post_rst2",   1, 0, 8'd0,  0, 2'b00, 8'hFF, 2, 0, RV,        0, 0, 1);
        add("post_rst3",   1, 0, 8'd0,  0, 2'b00, 8'hFF, 2, 0, RV + 8'd1, 0, 0, 1);
        run_table();

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised successor to the team's fixed 8-bit free-running counter. It counts up or down between 0 and a programmable limit, with a prescaler and synchronous load. Three end-of-range modes are selectable at run time: wrap, saturate, and one-shot. It also provides a terminal-count pulse and a sticky overflow flag. It sits between the top-level I/O wrapper and any logic that needs a programmable timebase or event counter.

## Interface
Parameters:
- WIDTH, 8, counter and limit width (≥2)
- RESET_VALUE, 0, count value after reset (WIDTH bits)
- PRESCALE_W, 4, width of prescale input and internal prescale counter (≥1)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-high
- enable  input  1  advances prescaler when high; all state holds when low (load/clear_ovf still act)
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value loaded on load
- dir  input  1  0 = count up, 1 = count down
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as 00
- limit  input  WIDTH  upper bound of count range [0, limit]
- prescale  input  PRESCALE_W  count advances once per prescale+1 enabled cycles
- clear_ovf  input  1  clears overflow
- count  output  WIDTH  current count (registered)
- tc  output  1  one-cycle terminal-count pulse (registered)
- overflow  output  1  sticky terminal-event flag
- running  output  1  high when counter is in RUN state

## Operation
- Reset values: count=RESET_VALUE, tc=0, overflow=0, running=1, prescale counter=0, state=RUN.
- Prescaler: when enable=1, the prescale counter is compared with prescale. If equal, a tick is generated and the prescale counter returns to 0; otherwise it increments. When enable=0, it holds. Load clears it to 0.
- Per-edge priority: reset > load > tick. With load=1: count=load_value, state=RUN, tc=0, and that cycle's tick is discarded.
- Terminal condition is evaluated at a tick:
  - Up: count ≥ limit.
  - Down: count == 0.
- Non-terminal tick: count ±1 modulo 2^WIDTH. An up-step never exceeds limit, because count ≥ limit is terminal.
- Terminal tick, by mode:
  - wrap, up: count=0. wrap, down: count=limit.
  - saturate, up: count=limit. saturate, down: count=0.
  - one-shot: count holds its value and state goes RUN→DONE.
  - In every mode: tc=1 for one cycle and overflow=1.
- Saturate: every further tick at the bound re-asserts tc. tc pulses once per tick while held.
- State machine has two states, RUN and DONE. running=(state==RUN).
  - RUN→DONE only on a one-shot terminal tick.
  - DONE→RUN on load, or when mode≠10 at any edge.
  - In DONE, ticks are ignored: count holds, tc=0, and the prescaler keeps running.
- overflow: set by a terminal tick, cleared by clear_ovf. If both occur in the same cycle, set wins.
- limit=0: every tick is terminal. Count is 0 in wrap/saturate (up or down).
- dir, mode and limit are sampled at each tick edge. Changing them mid-count takes effect on the next tick; no other state is altered.
- Arithmetic is unsigned WIDTH-bit. A loaded value above limit is legal: the next up-tick is terminal, and down-counting proceeds normally.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Load: count=load_value visible one edge after load is sampled high.
- Tick latency: with prescale=P and enable held high, count changes on every (P+1)-th edge after the prescaler is at 0.
- tc is high in the same cycle count shows the post-terminal value, for exactly one cycle.
- Reset is asynchronous: outputs take their reset values immediately on assertion, mid-count or mid-load. The first tick after deassertion occurs prescale+1 enabled edges later.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=0xC5 → count=0xC5, overflow=0, running=1. Then prescale=0, up, wrap, limit=0xFF, enable=1 → count goes 0xC6, 0xC7, … on consecutive edges.
- Wrap up: limit=9, load 8 → counts 9, then 0 with tc=1 for one cycle and overflow=1. Then clear_ovf → overflow=0.
- Down saturate with prescale=2: load 2, dir=1, mode=01 → 2,2,2,1,1,1,0 … then tc pulses every 3rd edge with count held at 0.
- One-shot: mode=10, limit=3, load 0 → 1,2,3, then tc=1 and running=0; count stays 3 for 10 cycles. Load 0 → running=1 and counting resumes.
- Simultaneous events: load and tick on the same edge → count=load_value, tc=0. Terminal tick with clear_ovf=1 → overflow=1.
- Async reset mid-count: assert reset between edges at count=5 → count=RESET_VALUE immediately, and the prescaler restarts from 0.
